// File: rtl/map_cmd_pkg.sv
// Shared definitions for the memory-map command initiator.
//   - Opcode values carried in the first byte of a command packet.
//   - Response byte constants (write acknowledge, bad-header error).
//   - FSM state encoding, also exported on the debug state output.
package map_cmd_pkg;

  localparam logic [7:0] OP_READ  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;

  localparam logic [7:0] ACK_BYTE = 8'hA5;
  localparam logic [7:0] ERR_BYTE = 8'hEE;

  typedef enum logic [3:0] {
    ST_HDR     = 4'd0,
    ST_ADDR_HI = 4'd1,
    ST_ADDR_LO = 4'd2,
    ST_DATA_HI = 4'd3,
    ST_DATA_LO = 4'd4,
    ST_WRITE   = 4'd5,
    ST_RD_WAIT = 4'd6,
    ST_TX_HI   = 4'd7,
    ST_TX_LO   = 4'd8,
    ST_TX_ACK  = 4'd9,
    ST_TX_ERR  = 4'd10
  } state_e;

  // True in the states that consume a command byte.
  function automatic logic is_rx_state(input state_e st);
    return (st == ST_HDR) || (st == ST_ADDR_HI) || (st == ST_ADDR_LO) ||
           (st == ST_DATA_HI) || (st == ST_DATA_LO);
  endfunction

endpackage

// File: rtl/byte_tx_reg.sv
// Registered holding stage for the response byte stream.
//
// Handshake: a byte moves when o_valid & i_ready are both high at a rising
// edge. Once o_valid is high, o_byte and o_valid hold until that handshake.
//
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset
//   i_load        load i_byte into the stage at the next edge (sets valid)
//   i_byte        byte to load
//   i_ready       downstream consumer ready
//   o_byte        registered response byte
//   o_valid       registered response valid
//   o_fire        handshake happening this cycle (o_valid & i_ready)
module byte_tx_reg (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [7:0] i_byte,
  input  logic       i_ready,
  output logic [7:0] o_byte,
  output logic       o_valid,
  output logic       o_fire
);

  logic [7:0] byte_q, byte_d;
  logic       valid_q, valid_d;

  // A load in the same cycle as a handshake replaces the consumed byte, which
  // lets back-to-back bytes move one per cycle.
  always_comb begin
    byte_d  = byte_q;
    valid_d = valid_q;
    if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
    if (i_load) begin
      valid_d = 1'b1;
      byte_d  = i_byte;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      byte_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      byte_q  <= byte_d;
      valid_q <= valid_d;
    end
  end

  assign o_byte  = byte_q;
  assign o_valid = valid_q;
  assign o_fire  = valid_q & i_ready;

endmodule

// File: rtl/map_cmd_initiator.sv
// Memory-map bus initiator driven by a byte-wide command stream.
//
// Command packets (big-endian):
//   read : 0x01 addrHi addrLo                 -> response dataHi dataLo
//   write: 0x02 addrHi addrLo dataHi dataLo   -> response 0xA5
//   any other header byte                     -> response 0xEE
//
// Handshake (both byte streams): a byte transfers on a rising edge where
// valid and ready are both high; the sender holds byte and valid stable
// until that edge.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_rxByte/i_rxValid/o_rxReady   command byte stream in
//   o_txByte/o_txValid/i_txReady   response byte stream out
//   o_memAddr, o_memDataOut, o_memWrEn   bus address, write data, strobe
//   i_memDataIn         bus read data (combinational from o_memAddr)
//   o_dbg_state         current FSM state
module map_cmd_initiator
  import map_cmd_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int RD_WAIT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_rxByte,
  input  logic              i_rxValid,
  output logic              o_rxReady,
  output logic [7:0]        o_txByte,
  output logic              o_txValid,
  input  logic              i_txReady,
  output logic [ADDR_W-1:0] o_memAddr,
  output logic [15:0]       o_memDataOut,
  output logic              o_memWrEn,
  input  logic [15:0]       i_memDataIn,
  output logic [3:0]        o_dbg_state
);

  localparam int CNT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_WAIT - 1);

  state_e            state_q, state_d;
  logic              first_q, first_d;
  logic              is_write_q, is_write_d;
  logic [7:0]        addr_hi_q, addr_hi_d;
  logic [7:0]        data_hi_q, data_hi_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_data_q, mem_data_d;
  logic [15:0]       rd_data_q, rd_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              rx_ready;
  logic              rx_fire;
  logic              tx_load;
  logic [7:0]        tx_load_byte;
  logic              tx_fire;
  logic              mem_wr_en;
  logic [15:0]       full_addr;

  // first_q blocks command intake for the first cycle after reset.
  assign rx_ready  = is_rx_state(state_q) && !first_q;
  assign rx_fire   = i_rxValid && rx_ready;
  assign full_addr = {addr_hi_q, i_rxByte};

  always_comb begin
    state_d      = state_q;
    first_d      = 1'b0;
    is_write_d   = is_write_q;
    addr_hi_d    = addr_hi_q;
    data_hi_d    = data_hi_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    rd_data_d    = rd_data_q;
    cnt_d        = cnt_q;
    tx_load      = 1'b0;
    tx_load_byte = 8'h00;
    mem_wr_en    = 1'b0;

    case (state_q)
      ST_HDR: begin
        if (rx_fire) begin
          if (i_rxByte == OP_READ) begin
            is_write_d = 1'b0;
            state_d    = ST_ADDR_HI;
          end else if (i_rxByte == OP_WRITE) begin
            is_write_d = 1'b1;
            state_d    = ST_ADDR_HI;
          end else begin
            tx_load      = 1'b1;
            tx_load_byte = ERR_BYTE;
            state_d      = ST_TX_ERR;
          end
        end
      end

      ST_ADDR_HI: begin
        if (rx_fire) begin
          addr_hi_d = i_rxByte;
          state_d   = ST_ADDR_LO;
        end
      end

      ST_ADDR_LO: begin
        if (rx_fire) begin
          // Upper address bits beyond ADDR_W are silently dropped.
          mem_addr_d = full_addr[ADDR_W-1:0];
          cnt_d      = '0;
          state_d    = is_write_q ? ST_DATA_HI : ST_RD_WAIT;
        end
      end

      ST_DATA_HI: begin
        if (rx_fire) begin
          data_hi_d = i_rxByte;
          state_d   = ST_DATA_LO;
        end
      end

      ST_DATA_LO: begin
        if (rx_fire) begin
          mem_data_d = {data_hi_q, i_rxByte};
          state_d    = ST_WRITE;
        end
      end

      ST_WRITE: begin
        // Address and data were registered on earlier edges, so they are
        // stable for the whole strobe cycle.
        mem_wr_en    = 1'b1;
        tx_load      = 1'b1;
        tx_load_byte = ACK_BYTE;
        state_d      = ST_TX_ACK;
      end

      ST_RD_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          // High byte goes straight into the output stage at capture time;
          // the low byte comes from the captured copy so later bus changes
          // cannot leak into the response.
          rd_data_d    = i_memDataIn;
          tx_load      = 1'b1;
          tx_load_byte = i_memDataIn[15:8];
          state_d      = ST_TX_HI;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_TX_HI: begin
        if (tx_fire) begin
          tx_load      = 1'b1;
          tx_load_byte = rd_data_q[7:0];
          state_d      = ST_TX_LO;
        end
      end

      ST_TX_LO, ST_TX_ACK, ST_TX_ERR: begin
        if (tx_fire) begin
          state_d = ST_HDR;
        end
      end

      default: begin
        state_d = ST_HDR;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_HDR;
      first_q    <= 1'b1;
      is_write_q <= 1'b0;
      addr_hi_q  <= 8'h00;
      data_hi_q  <= 8'h00;
      mem_addr_q <= '0;
      mem_data_q <= 16'h0000;
      rd_data_q  <= 16'h0000;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      is_write_q <= is_write_d;
      addr_hi_q  <= addr_hi_d;
      data_hi_q  <= data_hi_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      rd_data_q  <= rd_data_d;
      cnt_q      <= cnt_d;
    end
  end

  byte_tx_reg u_tx (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (tx_load),
    .i_byte  (tx_load_byte),
    .i_ready (i_txReady),
    .o_byte  (o_txByte),
    .o_valid (o_txValid),
    .o_fire  (tx_fire)
  );

  assign o_rxReady    = rx_ready;
  assign o_memAddr    = mem_addr_q;
  assign o_memDataOut = mem_data_q;
  assign o_memWrEn    = mem_wr_en;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_map_cmd_initiator.sv
module tb_map_cmd_initiator;
  import map_cmd_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT 1: ADDR_W=16, RD_WAIT=1
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_out;
  logic        mem_wr_en;
  logic [15:0] mem_data_in;
  logic [3:0]  dbg_state;
  logic [15:0] rd_val;

  // DUT 2: ADDR_W=2, RD_WAIT=3
  logic [7:0]  rx_byte2;
  logic        rx_valid2;
  logic        rx_ready2;
  logic [7:0]  tx_byte2;
  logic        tx_valid2;
  logic        tx_ready2;
  logic [1:0]  mem_addr2;
  logic [15:0] mem_data_out2;
  logic        mem_wr_en2;
  logic [15:0] mem_data_in2;
  logic [3:0]  dbg_state2;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int wr_cnt2  = 0;

  map_cmd_initiator #(.ADDR_W(16), .RD_WAIT(1)) u_dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rxByte     (rx_byte),
    .i_rxValid    (rx_valid),
    .o_rxReady    (rx_ready),
    .o_txByte     (tx_byte),
    .o_txValid    (tx_valid),
    .i_txReady    (tx_ready),
    .o_memAddr    (mem_addr),
    .o_memDataOut (mem_data_out),
    .o_memWrEn    (mem_wr_en),
    .i_memDataIn  (mem_data_in),
    .o_dbg_state  (dbg_state)
  );

  map_cmd_initiator #(.ADDR_W(2), .RD_WAIT(3)) u_dut2 (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rxByte     (rx_byte2),
    .i_rxValid    (rx_valid2),
    .o_rxReady    (rx_ready2),
    .o_txByte     (tx_byte2),
    .o_txValid    (tx_valid2),
    .i_txReady    (tx_ready2),
    .o_memAddr    (mem_addr2),
    .o_memDataOut (mem_data_out2),
    .o_memWrEn    (mem_wr_en2),
    .i_memDataIn  (mem_data_in2),
    .o_dbg_state  (dbg_state2)
  );

  // Satellite read model for DUT 1.
  always_comb begin
    case (mem_addr)
      16'h0003: mem_data_in = rd_val;
      16'h0002: mem_data_in = 16'h1357;
      default:  mem_data_in = 16'hC3A1;
    endcase
  end

  // Write strobe monitor.
  always @(negedge clk) begin
    if (mem_wr_en === 1'b1)  wr_cnt  = wr_cnt + 1;
    if (mem_wr_en2 === 1'b1) wr_cnt2 = wr_cnt2 + 1;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_byte(input int which, input logic [7:0] b);
    int n = 0;
    if (which == 1) begin rx_byte = b; rx_valid = 1'b1; end
    else begin rx_byte2 = b; rx_valid2 = 1'b1; end
    while (!((which == 1) ? rx_ready : rx_ready2) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("rx_ready_wait", (which == 1) ? rx_ready : rx_ready2, 1);
    @(posedge clk); #1;
    if (which == 1) rx_valid = 1'b0; else rx_valid2 = 1'b0;
  endtask

  task automatic recv_byte(input int which, input logic [7:0] exp, input string tag);
    int n = 0;
    if (which == 1) tx_ready = 1'b1; else tx_ready2 = 1'b1;
    while (!((which == 1) ? tx_valid : tx_valid2) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_valid"}, (which == 1) ? tx_valid : tx_valid2, 1);
    check(tag, (which == 1) ? tx_byte : tx_byte2, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    rx_byte = 8'h00;  rx_valid = 1'b0;  tx_ready = 1'b0;  rd_val = 16'hBEEF;
    rx_byte2 = 8'h00; rx_valid2 = 1'b0; tx_ready2 = 1'b0; mem_data_in2 = 16'h0000;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_addr",      mem_addr, 0);
    check("rst_data",      mem_data_out, 0);
    check("rst_wren",      mem_wr_en, 0);
    check("rst_txvalid",   tx_valid, 0);
    check("rst_txbyte",    tx_byte, 0);
    check("rst_rxready0",  rx_ready, 0);
    check("rst_state",     dbg_state, ST_HDR);
    @(posedge clk); #1;
    check("rst_rxready1",  rx_ready, 1);

    // Write 02 00 01 12 34
    send_byte(1, 8'h02); send_byte(1, 8'h00); send_byte(1, 8'h01);
    send_byte(1, 8'h12); send_byte(1, 8'h34);
    check("wr_strobe",     mem_wr_en, 1);
    check("wr_addr",       mem_addr, 16'h0001);
    check("wr_data",       mem_data_out, 16'h1234);
    check("wr_rxready",    rx_ready, 0);
    check("wr_txvalid_early", tx_valid, 0);
    @(posedge clk); #1;
    check("wr_strobe_off", mem_wr_en, 0);
    check("wr_ack_valid",  tx_valid, 1);
    check("wr_ack_byte",   tx_byte, ACK_BYTE);
    recv_byte(1, ACK_BYTE, "wr_ack");
    tx_ready = 1'b0;
    check("wr_back_hdr",   dbg_state, ST_HDR);
    check("wr_count",      wr_cnt, 1);

    // Read 01 00 03, data BEEF
    rd_val = 16'hBEEF;
    send_byte(1, 8'h01); send_byte(1, 8'h00); send_byte(1, 8'h03);
    check("rd_addr",       mem_addr, 16'h0003);
    check("rd_wait_novalid", tx_valid, 0);
    @(posedge clk); #1;
    check("rd_hi_valid",   tx_valid, 1);
    rd_val = 16'h0000;   // bus change after capture must not matter
    recv_byte(1, 8'hBE, "rd_hi");
    recv_byte(1, 8'hEF, "rd_lo");
    tx_ready = 1'b0;
    check("rd_done_novalid", tx_valid, 0);

    // Backpressure during read response
    rd_val = 16'hBEEF;
    send_byte(1, 8'h01); send_byte(1, 8'h00); send_byte(1, 8'h03);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_byte",    tx_byte, 8'hBE);
      check("bp_valid",   tx_valid, 1);
      check("bp_rxready", rx_ready, 0);
      @(posedge clk); #1;
    end
    recv_byte(1, 8'hBE, "bp_hi");
    recv_byte(1, 8'hEF, "bp_lo");
    check("bp_nodup",      tx_valid, 0);
    tx_ready = 1'b0;

    // Bad header then resync
    send_byte(1, 8'h7F);
    check("err_state",     dbg_state, ST_TX_ERR);
    recv_byte(1, ERR_BYTE, "err_byte");
    tx_ready = 1'b0;
    check("err_hdr",       dbg_state, ST_HDR);
    send_byte(1, 8'h01); send_byte(1, 8'h00); send_byte(1, 8'h02);
    recv_byte(1, 8'h13, "resync_hi");
    recv_byte(1, 8'h57, "resync_lo");
    tx_ready = 1'b0;
    check("err_wr_count",  wr_cnt, 1);

    // Reset mid-packet
    send_byte(1, 8'h02); send_byte(1, 8'h00); send_byte(1, 8'h01); send_byte(1, 8'h12);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_addr",    mem_addr, 0);
    check("mid_rst_data",    mem_data_out, 0);
    check("mid_rst_wren",    mem_wr_en, 0);
    check("mid_rst_txvalid", tx_valid, 0);
    check("mid_rst_txbyte",  tx_byte, 0);
    check("mid_rst_rxready", rx_ready, 0);
    check("mid_rst_state",   dbg_state, ST_HDR);
    send_byte(1, 8'h01); send_byte(1, 8'h00); send_byte(1, 8'h00);
    recv_byte(1, 8'hC3, "mid_rst_rd_hi");
    recv_byte(1, 8'hA1, "mid_rst_rd_lo");
    tx_ready = 1'b0;
    check("mid_rst_wr_count", wr_cnt, 1);

    // DUT 2: ADDR_W=2, RD_WAIT=3, address 0xFF02
    send_byte(2, 8'h01); send_byte(2, 8'hFF); send_byte(2, 8'h02);
    check("w3_addr",       mem_addr2, 2'b10);
    mem_data_in2 = 16'h1122;
    @(posedge clk); #1;
    check("w3_novalid1",   tx_valid2, 0);
    mem_data_in2 = 16'h3344;
    @(posedge clk); #1;
    check("w3_novalid2",   tx_valid2, 0);
    mem_data_in2 = 16'h5566;
    @(posedge clk); #1;
    check("w3_valid3",     tx_valid2, 1);
    mem_data_in2 = 16'h7788;
    recv_byte(2, 8'h55, "w3_hi");
    recv_byte(2, 8'h66, "w3_lo");
    tx_ready2 = 1'b0;
    check("w3_wr_count",   wr_cnt2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
